// File: rtl/synth_pkg.sv
// Shared sizing constants for the voice allocator and its key edge detector.
package synth_pkg;

  localparam int NUM_KEYS   = 4;
  localparam int NUM_VOICES = 2;
  localparam int KEY_W      = 2;
  localparam int DROP_W     = 4;

  localparam logic [DROP_W-1:0] DROP_MAX = 4'd15;

  typedef logic [KEY_W-1:0] key_idx_t;

endpackage

// File: rtl/key_edge_detect.sv
// Press/release detection on debounced key levels. The first edge after reset
// only loads key_prev, so keys held through reset do not count as presses.
module key_edge_detect #(
  parameter int NUM_KEYS = synth_pkg::NUM_KEYS
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] press,
  output logic [NUM_KEYS-1:0] rel
);

  logic [NUM_KEYS-1:0] key_prev;
  logic                armed;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_prev <= '0;
      armed    <= 1'b0;
    end else begin
      key_prev <= key_state;
      armed    <= 1'b1;
    end
  end

  assign press = armed ? (key_state & ~key_prev) : '0;
  assign rel   = armed ? (~key_state & key_prev) : '0;

endmodule

// File: rtl/voice_allocator.sv
// Shares NUM_VOICES tone voices between NUM_KEYS keys, serving one pending press per cycle.
// Define VOICE_STEAL_EN to steal the oldest voice when none is free; otherwise such presses are dropped.
module voice_allocator #(
  parameter int NUM_KEYS   = synth_pkg::NUM_KEYS,
  parameter int NUM_VOICES = synth_pkg::NUM_VOICES
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic [NUM_KEYS-1:0]                   key_state,
  output logic [NUM_VOICES-1:0]                 voice_active,
  output logic [NUM_VOICES*synth_pkg::KEY_W-1:0] voice_key,
  output logic [NUM_VOICES-1:0]                 voice_on,
  output logic [NUM_VOICES-1:0]                 voice_off,
  output logic                                  busy,
  output logic [synth_pkg::DROP_W-1:0]          drop_count
);

  localparam int KW = synth_pkg::KEY_W;

  logic [NUM_KEYS-1:0]   press;
  logic [NUM_KEYS-1:0]   rel;
  logic [NUM_KEYS-1:0]   pending;
  logic [NUM_KEYS-1:0]   cand;
  logic [NUM_KEYS-1:0]   serve_oh;
  logic                  serve_vld;
  synth_pkg::key_idx_t   serve_key;
  logic [NUM_VOICES-1:0] free_oh;
  logic                  free_vld;
  logic [NUM_VOICES-1:0] target_oh;

  key_edge_detect #(.NUM_KEYS(NUM_KEYS)) u_edge (
    .clk       (clk),
    .reset_n   (reset_n),
    .key_state (key_state),
    .press     (press),
    .rel       (rel)
  );

  // A key released at this edge is no longer a candidate even if still pending.
  always_comb begin
    cand      = pending & ~rel;
    serve_oh  = '0;
    serve_key = '0;
    serve_vld = 1'b0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (cand[k] && !serve_vld) begin
        serve_vld   = 1'b1;
        serve_oh[k] = 1'b1;
        serve_key   = synth_pkg::key_idx_t'(k);
      end
    end
    free_oh  = '0;
    free_vld = 1'b0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (!voice_active[v] && !free_vld) begin
        free_vld   = 1'b1;
        free_oh[v] = 1'b1;
      end
    end
  end

`ifdef VOICE_STEAL_EN
  // older[i][j] set means voice i was allocated before voice j.
  logic [NUM_VOICES-1:0][NUM_VOICES-1:0] older;
  logic [NUM_VOICES-1:0]                 victim_oh;

  always_comb begin
    victim_oh = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      victim_oh[v] = 1'b1;
      for (int u = 0; u < NUM_VOICES; u++) begin
        if (u != v && !older[v][u]) victim_oh[v] = 1'b0;
      end
    end
  end

  assign target_oh = free_vld ? free_oh : victim_oh;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      older <= '0;
    end else if (serve_vld) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (target_oh[v]) begin
          for (int u = 0; u < NUM_VOICES; u++) begin
            if (u != v) begin
              older[u][v] <= 1'b1;
              older[v][u] <= 1'b0;
            end
          end
        end
      end
    end
  end
`else
  assign target_oh = free_oh;
`endif

  // Voices freed by release are not in free_oh until the next edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending      <= '0;
      voice_active <= '0;
      voice_key    <= '0;
      voice_on     <= '0;
      voice_off    <= '0;
      drop_count   <= '0;
    end else begin
      voice_on  <= '0;
      voice_off <= '0;
      pending   <= (pending | press) & ~rel & ~serve_oh;
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (voice_active[v] && rel[voice_key[v*KW +: KW]]) begin
          voice_active[v] <= 1'b0;
          voice_off[v]    <= 1'b1;
        end
      end
      if (serve_vld) begin
        if (|target_oh) begin
          for (int v = 0; v < NUM_VOICES; v++) begin
            if (target_oh[v]) begin
              voice_active[v]       <= 1'b1;
              voice_key[v*KW +: KW] <= serve_key;
              voice_on[v]           <= 1'b1;
`ifdef VOICE_STEAL_EN
              if (!free_vld) voice_off[v] <= 1'b1;
`endif
            end
          end
        end else if (drop_count != synth_pkg::DROP_MAX) begin
          drop_count <= drop_count + 4'd1;
        end
      end
    end
  end

  assign busy = |pending;

endmodule

// File: tb/tb_voice_allocator.sv
// Scoreboard bench for voice_allocator: stimulus queues expected pulse events, a monitor checks them.
module tb_voice_allocator;

  logic       clk;
  logic       reset_n;
  logic [3:0] key_state;
  logic [1:0] voice_active;
  logic [3:0] voice_key;
  logic [1:0] voice_on;
  logic [1:0] voice_off;
  logic       busy;
  logic [3:0] drop_count;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    int         due;
    logic [1:0] on;
    logic [1:0] off;
    logic [1:0] act;
    logic [3:0] key;
    logic       bsy;
  } exp_t;

  exp_t q[$];

  voice_allocator dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .key_state    (key_state),
    .voice_active (voice_active),
    .voice_key    (voice_key),
    .voice_on     (voice_on),
    .voice_off    (voice_off),
    .busy         (busy),
    .drop_count   (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int due, input logic [1:0] on, input logic [1:0] off,
                      input logic [1:0] act, input logic [3:0] key, input logic bsy);
    exp_t e;
    e.due = due; e.on = on; e.off = off; e.act = act; e.key = key; e.bsy = bsy;
    q.push_back(e);
  endtask

  task automatic drive(input logic [3:0] k);
    @(negedge clk);
    key_state = k;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: any voice_on/voice_off pulse must match the next queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (voice_on != 2'b00 || voice_off != 2'b00) begin
        if (q.size() == 0) begin
          check("unexpected_pulse", {28'd0, voice_on, voice_off}, 32'd0);
        end else begin
          e = q.pop_front();
          check("event_cycle", cyc, e.due);
          check("voice_on", voice_on, e.on);
          check("voice_off", voice_off, e.off);
          check("voice_active", voice_active, e.act);
          check("voice_key", voice_key, e.key);
          check("busy", busy, e.bsy);
        end
      end
    end
  end

  initial begin
    #100000;
    fails++;
    $display("FAIL timeout: bench did not complete, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    int c;
    reset_n   = 1'b0;
    key_state = 4'b0000;
    idle(3);
    check("rst_active", voice_active, 2'b00);
    check("rst_key", voice_key, 4'b0000);
    check("rst_on", voice_on, 2'b00);
    check("rst_off", voice_off, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_drop", drop_count, 4'd0);
    reset_n = 1'b1;
    idle(2);

    // single key 2: on two edges after press, off one edge after release
    drive(4'b0100); c = cyc; push(c + 2, 2'b01, 2'b00, 2'b01, 4'b0010, 1'b0);
    idle(4);
    drive(4'b0000); c = cyc; push(c + 1, 2'b00, 2'b01, 2'b00, 4'b0010, 1'b0);
    idle(3);

    // keys 0 and 3 together: served on consecutive edges
    drive(4'b1001); c = cyc;
    push(c + 2, 2'b01, 2'b00, 2'b01, 4'b0000, 1'b1);
    push(c + 3, 2'b10, 2'b00, 2'b11, 4'b1100, 1'b0);
    idle(5);
    drive(4'b0000); c = cyc; push(c + 1, 2'b00, 2'b11, 2'b00, 4'b1100, 1'b0);
    idle(3);

    // key 1 released while pending behind key 0: never allocated
    drive(4'b0011); c = cyc; push(c + 2, 2'b01, 2'b00, 2'b01, 4'b1100, 1'b0);
    drive(4'b0001);
    idle(5);
    drive(4'b0000); c = cyc; push(c + 1, 2'b00, 2'b01, 2'b00, 4'b1100, 1'b0);
    idle(3);

    // fill both voices with keys 0 and 1, then press key 2
    drive(4'b0011); c = cyc;
    push(c + 2, 2'b01, 2'b00, 2'b01, 4'b1100, 1'b1);
    push(c + 3, 2'b10, 2'b00, 2'b11, 4'b0100, 1'b0);
    idle(4);
    drive(4'b0111); c = cyc;
`ifdef VOICE_STEAL_EN
    push(c + 2, 2'b01, 2'b01, 2'b11, 4'b0110, 1'b0);
    idle(4);
    check("steal_drop", drop_count, 4'd0);
    drive(4'b0000); c = cyc; push(c + 1, 2'b00, 2'b11, 2'b00, 4'b0110, 1'b0);
    idle(3);
`else
    idle(2);
    check("drop_first", drop_count, 4'd1);
    check("drop_active", voice_active, 2'b11);
    check("drop_busy", busy, 1'b0);
    // key 3 pending while key 0 releases: freed voice not usable at the same edge
    drive(4'b1111); c = cyc;
    drive(4'b1110);
    push(c + 2, 2'b00, 2'b01, 2'b10, 4'b0100, 1'b0);
    idle(2);
    check("same_edge_drop", drop_count, 4'd2);
    check("same_edge_active", voice_active, 2'b10);
    drive(4'b1111); c = cyc; push(c + 2, 2'b01, 2'b00, 2'b11, 4'b0100, 1'b0);
    idle(4);
    for (int i = 0; i < 20; i++) begin
      drive(4'b0111);
      drive(4'b1111);
      idle(2);
      check("drop_sat", drop_count, (i + 3 > 15) ? 4'd15 : 4'(i + 3));
    end
    drive(4'b0000); c = cyc; push(c + 1, 2'b00, 2'b11, 2'b00, 4'b0100, 1'b0);
    idle(3);
`endif

    // async reset with two voices active: silent drop, held keys ignored afterwards
    drive(4'b0011); c = cyc;
    push(c + 2, 2'b01, 2'b00, 2'b01, 4'b0100, 1'b1);
    push(c + 3, 2'b10, 2'b00, 2'b11, 4'b0100, 1'b0);
    idle(4);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async_active", voice_active, 2'b00);
    check("async_key", voice_key, 4'b0000);
    check("async_busy", busy, 1'b0);
    check("async_drop", drop_count, 4'd0);
    idle(3);
    reset_n = 1'b1;
    idle(5);
    check("held_busy", busy, 1'b0);
    drive(4'b0000);
    idle(2);
    drive(4'b0010); c = cyc; push(c + 2, 2'b01, 2'b00, 2'b01, 4'b0001, 1'b0);
    idle(4);
    drive(4'b0000); c = cyc; push(c + 1, 2'b00, 2'b01, 2'b00, 4'b0001, 1'b0);
    idle(4);

    check("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/voice_allocator.md
VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 The block SHALL have parameter NUM_KEYS, default 4, meaning number of key inputs (DO, RE, MI, FA).
REQ-002 The block SHALL have parameter NUM_VOICES, default 2, meaning number of tone-generator voices shared between keys.
REQ-003 The block SHALL have port clk, input, 1, meaning the single system clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1, meaning reset that is asynchronous and active-low.
REQ-005 The block SHALL have port key_state, input, NUM_KEYS, meaning the synchronized, debounced key levels (1 = pressed).
REQ-006 The block SHALL have port voice_active, output, NUM_VOICES, meaning voice v currently owns a key.
REQ-007 The block SHALL have port voice_key, output, NUM_VOICES*2, meaning the owning key index of voice v, packed at bits [2v+1:2v].
REQ-008 The block SHALL have port voice_on, output, NUM_VOICES, meaning a one-cycle pulse when voice v starts a note.
REQ-009 The block SHALL have port voice_off, output, NUM_VOICES, meaning a one-cycle pulse when voice v ends or loses its note.
REQ-010 The block SHALL have port busy, output, 1, meaning at least one press is pending allocation.
REQ-011 The block SHALL have port drop_count, output, 4, meaning saturating count of discarded presses.

Function
REQ-012 Press event: key_prev[k]=0 and key_state[k]=1 at a clock edge SHALL set pending[k] at that edge.
REQ-013 Release event: key_prev[k]=1 and key_state[k]=0 SHALL clear pending[k] and free any voice holding k, pulsing its voice_off, at that edge.
REQ-014 Exactly one pending key SHALL be served per cycle, lowest index first; served pending bit SHALL clear at the same edge.
REQ-015 A served key SHALL take the lowest-index free voice; voice_active, voice_key and one-cycle voice_on SHALL update at that edge.
REQ-016 Latency: voice_on SHALL assert in the cycle after the edge that set pending (2 edges after key_state first sampled high), absent earlier pending keys.
REQ-017 A voice freed by release at edge N SHALL be allocatable no earlier than edge N+1.
REQ-018 A key released while pending SHALL never be allocated.
REQ-019 The block SHALL track allocation age; the oldest active voice is the steal victim.
REQ-020 Press and release of the same key at the same edge are impossible (single level); releases of other keys and allocation at one edge SHALL both take effect.
REQ-021 drop_count SHALL saturate at 15 without wrapping.
REQ-022 busy SHALL equal OR of pending.

Reset
REQ-023 While reset_n=0: key_prev, pending, voice_active, voice_key, voice_on, voice_off, drop_count, age state SHALL all be zero.
REQ-024 Reset mid-note SHALL silently drop all voices without voice_off pulses; keys held through reset release SHALL NOT register as presses until released and pressed again (key_prev is loaded from key_state on the first active edge).

Configuration
REQ-025 With VOICE_STEAL_EN defined, a served key with no free voice SHALL steal the oldest voice: voice_off and voice_on pulse together on it, voice_key updates, and the stolen key is not re-queued.
REQ-026 Without VOICE_STEAL_EN, a served key with no free voice SHALL be discarded (pending cleared) and drop_count incremented.

Structure
REQ-027 NUM_KEYS, NUM_VOICES and key-index width SHALL live in shared package synth_pkg.
REQ-028 Edge detection (key_prev, press/release vectors) SHALL be sub-module key_edge_detect.

Verification
REQ-029 Reset release, press key 2 -> voice_on=01, voice_key[1:0]=2 two edges later; release -> voice_off=01 one edge later.
REQ-030 Keys 0 and 3 rise the same cycle -> key 0 gets voice 0 at edge+1, key 3 gets voice 1 at edge+2; busy high for exactly one cycle between them.
REQ-031 Keys 0, 1 held, press key 2, STEAL_EN -> voice 0 (oldest) pulses voice_off and voice_on together, voice_key[1:0]=2.
REQ-032 Same stimulus without STEAL_EN -> no voice change, drop_count=1; 20 further blocked presses -> drop_count=15.
REQ-033 Press key 1 then release after one cycle (still pending behind key 0) -> key 1 never allocated.
REQ-034 Assert reset_n=0 with two voices active -> all outputs zero asynchronously, no voice_off pulse.
